// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 for the pipelined MIPS core: SR, Cause, EPC, PRId.
// Raises the fetch redirect request and holds the eret return target.
module cp0_exception_unit #(
  parameter logic [31:0] PRID_VALUE   = 32'h2021_0007,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] RD
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc_q;

  logic        irq;
  logic        exc;
  logic [31:0] ret_pc;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  // Request terms, EPC candidate and readable register images
  always_comb begin
    irq    = (|(HWInt & im)) & ie & ~exl;
    exc    = (ExcCodeIn != 5'd0) & ~exl;
    IntReq = irq | exc;
    ret_pc = BDIn ? (PC - 32'd4) : PC;
    wr_sr  = WE && (A == 5'd12);
    wr_epc = WE && (A == 5'd14);
    sr_val = {16'd0, im, 8'd0, exl, ie};
    cause_val = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
    EPC    = epc_q;
  end

  // mfc0 read mux on the registered state
  always_comb begin
    RD = 32'd0;
    unique case (1'b1)
      (A == 5'd12): RD = sr_val;
      (A == 5'd13): RD = cause_val;
      (A == 5'd14): RD = epc_q;
      (A == 5'd15): RD = PRID_VALUE;
      default:      RD = 32'd0;
    endcase
  end

  // State update: reset > event entry > eret > mtc0
  always_ff @(posedge clk) begin
    if (!reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc_q    <= '0;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        exl      <= 1'b1;
        bd       <= BDIn;
        exc_code <= irq ? 5'd0 : ExcCodeIn;
        epc_q    <= {ret_pc[31:2], 2'b00};
      end else begin
        if (wr_sr) begin
          im  <= WD[15:10];
          ie  <= WD[0];
          exl <= EXLClr ? 1'b0 : WD[1];
        end else if (EXLClr) begin
          exl <= 1'b0;
        end
        if (wr_epc) begin
          epc_q <= {WD[31:2], 2'b00};
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed bench for cp0_exception_unit.
// Hand-computed expectations checked with immediate assertions.
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] RD;

  int vectors = 0;
  int miscompares = 0;

  cp0_exception_unit dut (
    .clk(clk), .reset(reset), .A(A), .WD(WD), .WE(WE),
    .PC(PC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .IntReq(IntReq), .EPC(EPC), .RD(RD)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a,
                        input logic [31:0] exp);
    A = a;
    #1;
    chk(tag, RD, exp);
  endtask

  initial begin
    reset = 1'b0; A = 5'd12; WD = 32'hFFFF_FFFF; WE = 1'b1;
    PC = 32'h0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'h3F;
    EXLClr = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_intreq", {31'd0, IntReq}, 32'd0);
    chk("rst_epc_out", EPC, 32'd0);
    rd_chk("rst_sr", 5'd12, 32'd0);
    rd_chk("rst_cause", 5'd13, 32'd0);
    rd_chk("rst_epc", 5'd14, 32'd0);
    rd_chk("prid", 5'd15, 32'h2021_0007);

    reset = 1'b1; HWInt = 6'h00; WE = 1'b1; A = 5'd12;
    WD = 32'h0000_0401;
    tick();
    WE = 1'b0;
    rd_chk("sr_wr", 5'd12, 32'h0000_0401);
    chk("idle_intreq", {31'd0, IntReq}, 32'd0);

    HWInt = 6'h01; PC = 32'h0000_3010; BDIn = 1'b0;
    #1;
    chk("irq_req", {31'd0, IntReq}, 32'd1);
    tick();
    chk("irq_self_mask", {31'd0, IntReq}, 32'd0);
    rd_chk("irq_sr", 5'd12, 32'h0000_0403);
    rd_chk("irq_cause", 5'd13, 32'h0000_0400);
    chk("irq_epc", EPC, 32'h0000_3010);

    HWInt = 6'h00; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    rd_chk("eret_sr", 5'd12, 32'h0000_0401);

    ExcCodeIn = 5'd10; PC = 32'h0000_3024; BDIn = 1'b1;
    #1;
    chk("exc_req", {31'd0, IntReq}, 32'd1);
    tick();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    rd_chk("exc_cause", 5'd13, 32'h8000_0028);
    chk("exc_epc", EPC, 32'h0000_3020);
    chk("exc_self_mask", {31'd0, IntReq}, 32'd0);

    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    HWInt = 6'h01; ExcCodeIn = 5'd4; PC = 32'h0000_3100;
    WE = 1'b1; A = 5'd14; WD = 32'h1234_5677;
    #1;
    chk("both_req", {31'd0, IntReq}, 32'd1);
    tick();
    ExcCodeIn = 5'd0; WE = 1'b0;
    rd_chk("both_cause", 5'd13, 32'h0000_0400);
    chk("both_epc_no_mtc0", EPC, 32'h0000_3100);
    chk("both_masked", {31'd0, IntReq}, 32'd0);

    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    #1;
    chk("refire_req", {31'd0, IntReq}, 32'd1);
    rd_chk("refire_sr", 5'd12, 32'h0000_0401);
    tick();
    chk("refire_masked", {31'd0, IntReq}, 32'd0);

    HWInt = 6'h00; EXLClr = 1'b1; WE = 1'b1; A = 5'd12;
    WD = 32'hFFFF_FFFF;
    tick();
    EXLClr = 1'b0; WE = 1'b0;
    rd_chk("eret_mtc0_sr", 5'd12, 32'h0000_FC01);

    WE = 1'b1; A = 5'd14; WD = 32'h1234_5677;
    tick();
    WE = 1'b0;
    rd_chk("mtc0_epc", 5'd14, 32'h1234_5674);
    chk("mtc0_epc_out", EPC, 32'h1234_5674);

    WE = 1'b1; A = 5'd13; WD = 32'hFFFF_FFFF;
    tick();
    WE = 1'b0;
    rd_chk("cause_ro", 5'd13, 32'h0000_0000);
    rd_chk("unimpl_reg", 5'd0, 32'h0000_0000);

    PC = 32'h0; BDIn = 1'b1; ExcCodeIn = 5'd1;
    #1;
    chk("pc0_req", {31'd0, IntReq}, 32'd1);
    tick();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    chk("pc0_epc", EPC, 32'hFFFF_FFFC);
    rd_chk("pc0_cause", 5'd13, 32'h8000_0004);

    ExcCodeIn = 5'd3;
    #1;
    chk("nested_masked", {31'd0, IntReq}, 32'd0);

    ExcCodeIn = 5'd0; HWInt = 6'h01; reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_intreq", {31'd0, IntReq}, 32'd0);
    rd_chk("midrst_sr", 5'd12, 32'd0);
    rd_chk("midrst_cause", 5'd13, 32'd0);
    rd_chk("midrst_epc", 5'd14, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
